// File: rtl/sha_pkg.sv
// Shared constants, state encoding and helper functions for the double-SHA-256 nonce searcher.
package sha_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HASH1 = 2'd1,
        HASH2 = 2'd2,
        FOUND = 2'd3
    } state_t;

    localparam logic [31:0] PAD_ONE = 32'h8000_0000;
    localparam logic [31:0] LEN_H1  = 32'h0000_0280;
    localparam logic [31:0] LEN_H2  = 32'h0000_0100;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] iv_state();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = IV[i];
        return r;
    endfunction

    // Wordwise mod-2^32 addition of two packed {A..H} states.
    function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
        return r;
    endfunction

    function automatic logic [255:0] byterev256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round on a packed {A..H} state.
module sha256_round
    import sha_pkg::*;
(
    input  logic [255:0] state_i,
    input  logic [31:0]  k_i,
    input  logic [31:0]  w_i,
    output logic [255:0] state_o
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_i;
    assign t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_i + w_i;
    assign t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha_hasher.sv
// Iterative double-SHA-256 nonce search: one round per clock, compact-target compare,
// nonce stepping on a miss and result hold on a hit.
module sha_hasher
    import sha_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         write_en,
    input  logic [255:0] digest_intial,
    input  logic [255:0] digest_in,
    input  logic [31:0]  merkle_in,
    input  logic [31:0]  time_in,
    input  logic [31:0]  target_in,
    input  logic [31:0]  nonce_in,
    output logic         valid_out,
    output logic [31:0]  time_out,
    output logic [31:0]  nonce_out,
    output logic [255:0] result_out
);
    state_t       fsm_q, fsm_d;
    logic [6:0]   round_q, round_d;
    logic [255:0] st_q, st_d, mid_q, mid_d;
    logic [31:0]  merkle_q, merkle_d, target_q, target_d;
    logic [31:0]  time_counter_reg, time_counter_d, nonce_counter_reg, nonce_counter_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic         write_en_q;
    logic         valid_q, valid_d;
    logic [31:0]  time_out_q, time_out_d, nonce_out_q, nonce_out_d;
    logic [255:0] result_q, result_d;

    logic [255:0] round_out, h1, digest, hash_val, tgt;
    logic [31:0]  w_new, nbits, nonce_inc, time_inc;
    logic         load, hit;

    sha256_round u_round (
        .state_i (st_q),
        .k_i     (K[round_q[5:0]]),
        .w_i     (w_q[0]),
        .state_o (round_out)
    );

    assign load   = write_en & ~write_en_q;
    assign w_new  = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    assign h1     = add8(st_q, mid_q);
    assign digest = add8(st_q, iv_state());
    assign hash_val  = byterev256(digest);
    assign nonce_inc = nonce_counter_reg + 32'd1;
    assign time_inc  = time_counter_reg + {31'd0, (nonce_inc == 32'd0)};

    // Compact nBits expansion: mantissa shifted by whole bytes around exponent 3.
    always_comb begin
        nbits = {target_q[7:0], target_q[15:8], target_q[23:16], target_q[31:24]};
        tgt   = '0;
        if (nbits[31:24] >= 8'd3)
            tgt = {232'd0, nbits[23:0]} << {nbits[31:24] - 8'd3, 3'b000};
        else
            tgt = {232'd0, nbits[23:0]} >> {2'd3 - nbits[25:24], 3'b000};
    end

    assign hit = (hash_val <= tgt);

    always_comb begin
        fsm_d           = fsm_q;
        round_d         = round_q;
        st_d            = st_q;
        mid_d           = mid_q;
        merkle_d        = merkle_q;
        target_d        = target_q;
        time_counter_d  = time_counter_reg;
        nonce_counter_d = nonce_counter_reg;
        w_d             = w_q;
        valid_d         = valid_q;
        time_out_d      = time_out_q;
        nonce_out_d     = nonce_out_q;
        result_d        = result_q;

        case (fsm_q)
            HASH1, HASH2: begin
                if (!round_q[6]) begin
                    st_d    = round_out;
                    round_d = round_q + 7'd1;
                    for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                    w_d[15] = w_new;
                end else if (fsm_q == HASH1) begin
                    st_d    = iv_state();
                    round_d = '0;
                    fsm_d   = HASH2;
                    w_d     = '{h1[255:224], h1[223:192], h1[191:160], h1[159:128],
                                h1[127:96],  h1[95:64],   h1[63:32],   h1[31:0],
                                PAD_ONE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, LEN_H2};
                end else begin
                    result_d    = digest;
                    time_out_d  = time_counter_reg;
                    nonce_out_d = nonce_counter_reg;
                    if (hit) begin
                        valid_d = 1'b1;
                        fsm_d   = FOUND;
                    end else begin
                        nonce_counter_d = nonce_inc;
                        time_counter_d  = time_inc;
                        st_d    = mid_q;
                        round_d = '0;
                        fsm_d   = HASH1;
                        w_d     = '{merkle_q, time_inc, target_q, nonce_inc, PAD_ONE,
                                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                    32'd0, 32'd0, 32'd0, 32'd0, 32'd0, LEN_H1};
                    end
                end
            end
            default: ;
        endcase

        // Round 0 of the first block-2 pass is already folded into digest_in,
        // so the schedule starts at W1 with W16 precomputed.
        if (load) begin
            mid_d           = digest_intial;
            merkle_d        = merkle_in;
            target_d        = target_in;
            time_counter_d  = time_in;
            nonce_counter_d = nonce_in;
            valid_d         = 1'b0;
            st_d            = digest_in;
            round_d         = 7'd1;
            fsm_d           = HASH1;
            w_d             = '{time_in, target_in, nonce_in, PAD_ONE,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0, LEN_H1,
                                ssig0(time_in) + merkle_in};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fsm_q             <= IDLE;
            round_q           <= '0;
            st_q              <= '0;
            mid_q             <= '0;
            merkle_q          <= '0;
            target_q          <= '0;
            time_counter_reg  <= '0;
            nonce_counter_reg <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
            write_en_q        <= 1'b0;
            valid_q           <= 1'b0;
            time_out_q        <= '0;
            nonce_out_q       <= '0;
            result_q          <= '0;
        end else begin
            fsm_q             <= fsm_d;
            round_q           <= round_d;
            st_q              <= st_d;
            mid_q             <= mid_d;
            merkle_q          <= merkle_d;
            target_q          <= target_d;
            time_counter_reg  <= time_counter_d;
            nonce_counter_reg <= nonce_counter_d;
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
            write_en_q        <= write_en;
            valid_q           <= valid_d;
            time_out_q        <= time_out_d;
            nonce_out_q       <= nonce_out_d;
            result_q          <= result_d;
        end
    end

    assign valid_out  = valid_q;
    assign time_out   = time_out_q;
    assign nonce_out  = nonce_out_q;
    assign result_out = result_q;

endmodule

// File: tb/tb_sha_hasher.sv
// Directed bench for sha_hasher using a known lucky Bitcoin header and impossible-target variants.
module tb_sha_hasher;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         write_en = 1'b0;
    logic [255:0] digest_intial = '0;
    logic [255:0] digest_in = '0;
    logic [31:0]  merkle_in = '0, time_in = '0, target_in = '0, nonce_in = '0;
    logic         valid_out;
    logic [31:0]  time_out, nonce_out;
    logic [255:0] result_out;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [255:0] MID  = 256'hF59007B5_7A2E5616_B8F47922_F4A62AA5_F6F59658_8185BBAE_FA09E776_3BC75771;
    localparam logic [255:0] DIN  = 256'hF7A528B9_F59007B5_7A2E5616_B8F47922_F2C1816D_F6F59658_8185BBAE_FA09E776;
    localparam logic [255:0] GOLD = 256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000;
    localparam logic [31:0]  LUCKY_TGT = 32'h6461011a;
    localparam logic [31:0]  NO_TGT    = 32'h00000003;

    sha_hasher dut (
        .CLK(CLK), .RST(RST), .write_en(write_en),
        .digest_intial(digest_intial), .digest_in(digest_in),
        .merkle_in(merkle_in), .time_in(time_in), .target_in(target_in), .nonce_in(nonce_in),
        .valid_out(valid_out), .time_out(time_out), .nonce_out(nonce_out), .result_out(result_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves the bench just after edge 0 (the load edge).
    task automatic load(input logic [31:0] tgt, input logic [31:0] nonce, input bit hold);
        write_en = 1'b0;
        tick(1);
        digest_intial = MID;
        digest_in     = DIN;
        merkle_in     = 32'h252db801;
        time_in       = 32'h130dae51;
        target_in     = tgt;
        nonce_in      = nonce;
        write_en      = 1'b1;
        tick(1);
        if (!hold) write_en = 1'b0;
    endtask

    initial begin
        tick(3);
        chk("rst_valid", {255'd0, valid_out}, 256'd0);
        chk("rst_result", result_out, 256'd0);
        chk("rst_nonce", {224'd0, nonce_out}, 256'd0);
        RST = 1'b0;
        tick(1);

        // Lucky vector, write_en held high for 300 cycles.
        load(LUCKY_TGT, 32'h3aeb9bb8, 1'b1);
        chk("load_time_cnt", {224'd0, dut.time_counter_reg}, {224'd0, 32'h130dae51});
        chk("load_nonce_cnt", {224'd0, dut.nonce_counter_reg}, {224'd0, 32'h3aeb9bb8});
        tick(128);
        chk("lucky_e128_valid", {255'd0, valid_out}, 256'd0);
        tick(1);
        chk("lucky_valid", {255'd0, valid_out}, 256'd1);
        chk("lucky_time", {224'd0, time_out}, {224'd0, 32'h130dae51});
        chk("lucky_nonce", {224'd0, nonce_out}, {224'd0, 32'h3aeb9bb8});
        chk("lucky_result", result_out, GOLD);
        tick(171);
        chk("hold_valid", {255'd0, valid_out}, 256'd1);
        chk("hold_result", result_out, GOLD);
        chk("hold_nonce_cnt", {224'd0, dut.nonce_counter_reg}, {224'd0, 32'h3aeb9bb8});
        write_en = 1'b0;

        // Impossible target: miss, one nonce step per 130 edges.
        load(NO_TGT, 32'h3aeb9bb8, 1'b0);
        chk("miss_clears_valid", {255'd0, valid_out}, 256'd0);
        tick(128);
        chk("miss_nonce_cnt_e128", {224'd0, dut.nonce_counter_reg}, {224'd0, 32'h3aeb9bb8});
        tick(1);
        chk("miss_valid", {255'd0, valid_out}, 256'd0);
        chk("miss_nonce_out", {224'd0, nonce_out}, {224'd0, 32'h3aeb9bb8});
        chk("miss_nonce_cnt", {224'd0, dut.nonce_counter_reg}, {224'd0, 32'h3aeb9bb9});
        tick(129);
        chk("miss2_nonce_out_early", {224'd0, nonce_out}, {224'd0, 32'h3aeb9bb8});
        tick(1);
        chk("miss2_nonce_out", {224'd0, nonce_out}, {224'd0, 32'h3aeb9bb9});
        chk("miss2_nonce_cnt", {224'd0, dut.nonce_counter_reg}, {224'd0, 32'h3aeb9bba});
        chk("miss2_valid", {255'd0, valid_out}, 256'd0);

        // Nonce wrap carries into the time counter.
        load(NO_TGT, 32'hFFFFFFFF, 1'b0);
        tick(129);
        chk("wrap_nonce_cnt", {224'd0, dut.nonce_counter_reg}, 256'd0);
        chk("wrap_time_cnt", {224'd0, dut.time_counter_reg}, {224'd0, 32'h130dae52});
        chk("wrap_time_out", {224'd0, time_out}, {224'd0, 32'h130dae51});
        chk("wrap_nonce_out", {224'd0, nonce_out}, {224'd0, 32'hFFFFFFFF});

        // Async reset mid-hash.
        load(LUCKY_TGT, 32'h3aeb9bb8, 1'b0);
        tick(59);
        #2 RST = 1'b1;
        #1;
        chk("arst_result", result_out, 256'd0);
        chk("arst_time", {224'd0, time_out}, 256'd0);
        chk("arst_nonce", {224'd0, nonce_out}, 256'd0);
        chk("arst_valid", {255'd0, valid_out}, 256'd0);
        tick(2);
        RST = 1'b0;
        tick(200);
        chk("arst_no_valid", {255'd0, valid_out}, 256'd0);
        chk("arst_no_result", result_out, 256'd0);
        load(LUCKY_TGT, 32'h3aeb9bb8, 1'b0);
        tick(129);
        chk("reload_valid", {255'd0, valid_out}, 256'd1);
        chk("reload_result", result_out, GOLD);

        // Abort: fresh load while a search is in flight.
        load(NO_TGT, 32'h3aeb9bb8, 1'b0);
        tick(99);
        load(LUCKY_TGT, 32'h3aeb9bb8, 1'b0);
        tick(128);
        chk("abort_e128_valid", {255'd0, valid_out}, 256'd0);
        tick(1);
        chk("abort_valid", {255'd0, valid_out}, 256'd1);
        chk("abort_result", result_out, GOLD);
        chk("abort_nonce", {224'd0, nonce_out}, {224'd0, 32'h3aeb9bb8});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sha_hasher.md
Name: sha_hasher

Overview:
- Iterative Bitcoin double-SHA-256 nonce searcher; sits behind the work-distribution logic of the miner.
- Takes a precomputed first-block midstate plus the 4 variable header words (merkle tail, time, bits, nonce).
- Hashes SHA256(SHA256(header)) one round per clock and checks the result against the compact target.
- Steps the nonce on a miss; stops and holds time/nonce/result on a hit.

Parameters:
- none (all widths fixed by SHA-256 / Bitcoin header format)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high; clears all state and outputs
- write_en  in  1  load request; a rising edge (1 now, 0 on previous clock) loads new work
- digest_intial  in  256  first-block midstate {A..H}, added at end of hash 1
- digest_in  in  256  working state after round 0 of header block 2 (W0=merkle_in already applied)
- merkle_in  in  32  header block-2 word W0
- time_in  in  32  W1, header byte order
- target_in  in  32  W2 (nBits, header byte order)
- nonce_in  in  32  W3, start nonce
- valid_out  out  1  result meets target; held
- time_out  out  32  time word of the reported result
- nonce_out  out  32  nonce word of the reported result
- result_out  out  256  second digest {H0..H7}, raw SHA byte order

Behaviour:
- Reset: all outputs, counters, state regs and write_en_q go to 0; FSM goes to IDLE.
- Load (write_en & ~write_en_q at a clock edge, any state):
  - latch digest_intial, digest_in, merkle_in, target_in;
  - time_counter_reg <= time_in, nonce_counter_reg <= nonce_in;
  - valid_out <= 0; enter HASH1 at round 1.
  - An in-progress search is aborted.
  - Level-held write_en loads only once.
- Block-2 message, hash 1:
  - W0..W3 = merkle, time_counter, target, nonce_counter;
  - W4 = 0x80000000; W5..W14 = 0; W15 = 0x00000280.
- Hash 2:
  - message W0..W7 = hash-1 digest; W8 = 0x80000000; W9..W14 = 0; W15 = 0x00000100;
  - initial state = standard SHA-256 IV.
- Schedule: 16-word shift register; W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] computed on the fly.
- Timing, edge 0 = load:
  - edges 1..63: hash-1 rounds 1..63, starting from digest_in;
  - edge 64: H1 = state + digest_intial, wordwise mod 2^32; state <= IV; enter HASH2;
  - edges 65..128: hash-2 rounds 0..63;
  - edge 129: digest = state + IV; register outputs:
    - result_out <= digest;
    - time_out/nonce_out <= the counters used for it;
    - valid_out <= hit.
- Hit test (combinational on the edge-129 digest):
  - nbits = byteswap32(target_in); E = nbits[31:24]; M = nbits[23:0];
  - target = M << 8*(E-3); for E<3 use M >> 8*(3-E);
  - hash value = byte-reversal of the 256-bit digest;
  - hit = hash value <= target (unsigned 256-bit).
- On hit: enter FOUND; outputs held until reset or a new load.
- On miss:
  - nonce_counter_reg += 1 (plain 32-bit increment of the word);
  - if the nonce wraps FFFFFFFF->0, time_counter_reg += 1;
  - restart HASH1 at round 0 using digest_intial as start state (W0 now computed in hardware);
  - a miss iteration is 130 edges.
- First iteration uses digest_in, so hit latency from load is exactly 129 edges.
- result_out/time_out/nonce_out update after every completed hash, valid_out only on a hit.
- Async RST mid-hash aborts immediately; outputs read 0 until the next load completes.

Decomposition:
- Package sha_pkg:
  - K[0:63] round constants;
  - IV[0:7];
  - padding constants 0x80000000, 0x280, 0x100;
  - FSM state enum IDLE/HASH1/HASH2/FOUND.
- Sub-module sha256_round: combinational one round.
  - inputs: 256-bit state, K, W;
  - output: next 256-bit state (Ch, Maj, Sigma0/1).
- Schedule, counters, target expansion and compare live in the top.

Test Plan:
- Lucky first input:
  - stimulus: merkle_in=252db801, time_in=130dae51, target_in=6461011a, nonce_in=3aeb9bb8;
  - digest_intial = F59007B5 7A2E5616 B8F47922 F4A62AA5 F6F59658 8185BBAE FA09E776 3BC75771;
  - digest_in = F7A528B9 F59007B5 7A2E5616 B8F47922 F2C1816D F6F59658 8185BBAE FA09E776;
  - required at edge 129: valid_out=1, time_out=130dae51, nonce_out=3aeb9bb8;
  - required at edge 129: result_out = 5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000.
- Load check: edge after the write_en rise -> time_counter_reg=130dae51, nonce_counter_reg=3aeb9bb8. Hold write_en high 300 cycles -> no reload, outputs stay held.
- Impossible target (target_in=00000003) with the same inputs:
  - edge 129: valid_out=0, nonce_out=3aeb9bb8;
  - nonce_counter_reg=3aeb9bb9, one increment per further 130 edges.
- Nonce wrap: nonce_in=FFFFFFFF with impossible target -> after first completion nonce_counter_reg=0, time_counter_reg=130dae52.
- RST pulse at edge 60 of the lucky vector -> all outputs 0. No valid_out until reload; reload gives the same result at edge 129 after the load.
- Abort: new write_en rising edge at edge 100 -> search restarts; results appear at edge 129 after the new load.
